// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage of the RV32I multi-cycle core. Holds the PC, requests one
//   instruction word at a time from instruction memory over a req/ready
//   handshake, latches it into the instruction register (instrCode) and holds
//   it until the core signals advance. The next PC is pc+4 or a redirect
//   target. Also counts retired instructions and flags a memory timeout.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   imem_req/imem_addr        fetch request and address (= pc)
//   imem_ready/imem_rdata     memory response, sampled only while requesting
//   instr_valid/instrCode     fetched instruction, valid until advanced
//   pc/pc_plus4               address of instrCode and its link value
//   advance/redirect/redirect_pc  consume instruction, choose next PC
//   misalign                  one-cycle pulse on a misaligned redirect target
//   fetch_err                 sticky memory timeout flag
//   instret                   accepted-advance counter (wraps)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instrCode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign,
  output logic        fetch_err,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {S_RST = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2, S_ERR = 2'd3} state_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [7:0]  wait_cnt_r, wait_cnt_s, wait_cnt_inc_s;
  logic        misalign_r, misalign_s;
  logic        fetch_err_r, fetch_err_s;
  logic [31:0] instret_r, instret_s;
  logic        req_r, req_s;
  logic        valid_r, valid_s;

  assign pc_plus4       = pc_r + 32'd4;
  assign wait_cnt_inc_s = wait_cnt_r + 8'd1;

  // Next-state and next-value logic for all fetch-stage registers.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    instr_s     = instr_r;
    wait_cnt_s  = wait_cnt_r;
    misalign_s  = 1'b0;
    fetch_err_s = fetch_err_r;
    instret_s   = instret_r;
    case (state_r)
      S_RST: begin
        state_s = S_REQ;
      end
      S_REQ: begin
        // A response on the timeout edge still wins over the error.
        if (imem_ready) begin
          instr_s    = imem_rdata;
          wait_cnt_s = 8'd0;
          state_s    = S_HOLD;
        end else if (wait_cnt_inc_s == TIMEOUT_C) begin
          wait_cnt_s  = wait_cnt_inc_s;
          fetch_err_s = 1'b1;
          state_s     = S_ERR;
        end else begin
          wait_cnt_s = wait_cnt_inc_s;
        end
      end
      S_HOLD: begin
        if (advance) begin
          instret_s = instret_r + 32'd1;
          state_s   = S_REQ;
          if (redirect) begin
            pc_s       = {redirect_pc[31:2], 2'b00};
            misalign_s = |redirect_pc[1:0];
          end else begin
            pc_s = pc_plus4;
          end
        end else begin
          state_s = S_HOLD;
        end
      end
      S_ERR: begin
        state_s = S_ERR;
      end
      default: begin
        state_s = S_RST;
      end
    endcase
    // Handshake outputs are registered from the next state so they change
    // together with the state register.
    req_s   = (state_s == S_REQ);
    valid_s = (state_s == S_HOLD);
  end

  // Fetch-stage state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_RST;
      pc_r        <= RESET_PC;
      instr_r     <= NOP;
      wait_cnt_r  <= 8'd0;
      misalign_r  <= 1'b0;
      fetch_err_r <= 1'b0;
      instret_r   <= 32'd0;
      req_r       <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      instr_r     <= instr_s;
      wait_cnt_r  <= wait_cnt_s;
      misalign_r  <= misalign_s;
      fetch_err_r <= fetch_err_s;
      instret_r   <= instret_s;
      req_r       <= req_s;
      valid_r     <= valid_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = valid_r;
  assign instrCode   = instr_r;
  assign pc          = pc_r;
  assign misalign    = misalign_r;
  assign fetch_err   = fetch_err_r;
  assign instret     = instret_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instrCode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic        fetch_err;
  logic [31:0] instret;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instrCode(instrCode),
    .pc(pc), .pc_plus4(pc_plus4),
    .advance(advance), .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign(misalign), .fetch_err(fetch_err), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        adv;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        req;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    logic [31:0] iret;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic valid,
                         input logic [31:0] epc, input logic [31:0] instr,
                         input logic mis, input logic [31:0] iret, input logic ferr);
    chk({tag, "_req"},   {31'd0, imem_req},    {31'd0, req});
    chk({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, valid});
    chk({tag, "_pc"},    pc,                   epc);
    chk({tag, "_addr"},  imem_addr,            epc);
    chk({tag, "_pc4"},   pc_plus4,             epc + 32'd4);
    chk({tag, "_instr"}, instrCode,            instr);
    chk({tag, "_mis"},   {31'd0, misalign},    {31'd0, mis});
    chk({tag, "_iret"},  instret,              iret);
    chk({tag, "_ferr"},  {31'd0, fetch_err},   {31'd0, ferr});
  endtask

  // Drive one cycle of inputs, then sample just after the active edge.
  task automatic step(input logic adv, input logic redir, input logic [31:0] rpc,
                      input logic rdy, input logic [31:0] rdata);
    advance     = adv;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        adv  red  rpc           rdy  rdata          req  val  pc            instr          mis  iret
    tbl[0]  = '{1'b0,1'b0,32'h0,       1'b1,32'h00500093, 1'b1,1'b0,32'h00,      32'h00000013, 1'b0,32'd0};
    tbl[1]  = '{1'b0,1'b0,32'h0,       1'b1,32'h00500093, 1'b0,1'b1,32'h00,      32'h00500093, 1'b0,32'd0};
    tbl[2]  = '{1'b1,1'b0,32'h0,       1'b1,32'h11111111, 1'b1,1'b0,32'h04,      32'h00500093, 1'b0,32'd1};
    tbl[3]  = '{1'b0,1'b0,32'h0,       1'b1,32'h22222222, 1'b0,1'b1,32'h04,      32'h22222222, 1'b0,32'd1};
    tbl[4]  = '{1'b1,1'b0,32'h0,       1'b1,32'h22222222, 1'b1,1'b0,32'h08,      32'h22222222, 1'b0,32'd2};
    tbl[5]  = '{1'b0,1'b0,32'h0,       1'b1,32'h33333333, 1'b0,1'b1,32'h08,      32'h33333333, 1'b0,32'd2};
    tbl[6]  = '{1'b1,1'b0,32'h0,       1'b1,32'h33333333, 1'b1,1'b0,32'h0C,      32'h33333333, 1'b0,32'd3};
    tbl[7]  = '{1'b0,1'b0,32'h0,       1'b1,32'h44444444, 1'b0,1'b1,32'h0C,      32'h44444444, 1'b0,32'd3};
    tbl[8]  = '{1'b1,1'b0,32'h0,       1'b1,32'h44444444, 1'b1,1'b0,32'h10,      32'h44444444, 1'b0,32'd4};
    // advance+redirect while requesting: ignored
    tbl[9]  = '{1'b1,1'b1,32'h22,      1'b1,32'h55555555, 1'b0,1'b1,32'h10,      32'h55555555, 1'b0,32'd4};
    // redirect without advance: no effect
    tbl[10] = '{1'b0,1'b1,32'h22,      1'b1,32'h55555555, 1'b0,1'b1,32'h10,      32'h55555555, 1'b0,32'd4};
    tbl[11] = '{1'b1,1'b1,32'h22,      1'b1,32'h55555555, 1'b1,1'b0,32'h20,      32'h55555555, 1'b1,32'd5};
    // ready withheld three cycles, word taken on the fourth
    tbl[12] = '{1'b0,1'b0,32'h0,       1'b0,32'h66666666, 1'b1,1'b0,32'h20,      32'h55555555, 1'b0,32'd5};
    tbl[13] = '{1'b0,1'b0,32'h0,       1'b0,32'h66666666, 1'b1,1'b0,32'h20,      32'h55555555, 1'b0,32'd5};
    tbl[14] = '{1'b0,1'b0,32'h0,       1'b0,32'h66666666, 1'b1,1'b0,32'h20,      32'h55555555, 1'b0,32'd5};
    tbl[15] = '{1'b0,1'b0,32'h0,       1'b1,32'h66666666, 1'b0,1'b1,32'h20,      32'h66666666, 1'b0,32'd5};
    tbl[16] = '{1'b1,1'b1,32'h40,      1'b1,32'h0,        1'b1,1'b0,32'h40,      32'h66666666, 1'b0,32'd6};

    reset_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_all("rst", 1'b0, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].adv, tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].rdata);
      chk_all($sformatf("v%0d", i), tbl[i].req, tbl[i].valid, tbl[i].pc,
              tbl[i].instr, tbl[i].mis, tbl[i].iret, 1'b0);
    end

    // Ready arrives on the edge the wait count reaches TIMEOUT: no error.
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_all($sformatf("lw%0d", i), 1'b1, 1'b0, 32'h40, 32'h66666666, 1'b0, 32'd6, 1'b0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h77777777);
    chk_all("late_ok", 1'b0, 1'b1, 32'h40, 32'h77777777, 1'b0, 32'd6, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_all("adv44", 1'b1, 1'b0, 32'h44, 32'h77777777, 1'b0, 32'd7, 1'b0);

    // Ready withheld TIMEOUT cycles: sticky error.
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_all($sformatf("tw%0d", i), 1'b1, 1'b0, 32'h44, 32'h77777777, 1'b0, 32'd7, 1'b0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_all("tmo", 1'b0, 1'b0, 32'h44, 32'h77777777, 1'b0, 32'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'h80, 1'b1, 32'h88888888);
      chk_all($sformatf("err%0d", i), 1'b0, 1'b0, 32'h44, 32'h77777777, 1'b0, 32'd7, 1'b1);
    end

    // Reset mid-request; a late ready must be ignored.
    reset_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_all("preq", 1'b1, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);
    #2;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    reset_n    = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    chk_all("rst_hold", 1'b0, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h00A00113);
    chk_all("refetch_req", 1'b1, 1'b0, 32'h0, 32'h13, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h00A00113);
    chk_all("refetch", 1'b0, 1'b1, 32'h0, 32'h00A00113, 1'b0, 32'd0, 1'b0);

    // PC wrap from 0xFFFF_FFFC.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk_all("to_top", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h00A00113, 1'b0, 32'd1, 1'b0);
    chk("top_pc4", pc_plus4, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678);
    chk_all("top_hold", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h12345678, 1'b0, 32'd1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_all("wrap", 1'b1, 1'b0, 32'h0, 32'h12345678, 1'b0, 32'd2, 1'b0);
    chk("wrap_pc4", pc_plus4, 32'h0000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
